// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry.
//
// Lookup is combinational from if_pc. Updates arrive from decode once a BEQ
// has resolved, and are written on the rising clock edge. A lookup in the
// same cycle as an update sees the table contents from before the update.
//
// btb_clr invalidates every entry. It also discards any update presented in
// the same cycle.
//
// Optional build macro: BRPRED_STATS_EN.
//   When defined, the block adds the stat_branches and stat_mispred
//   performance counters.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic        btb_clr
`ifdef BRPRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Saturating 2-bit counter step: move toward ST when taken, toward SNT
    // otherwise.
    function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

    // Table storage.
    // Valid bits and counters are reset. Tags and targets are not, because
    // they are only ever seen through a set valid bit.
    logic [ENTRIES-1:0] validTable_r;
    logic [1:0]         ctrTable_r    [ENTRIES];
    logic [TAG_W-1:0]   tagTable_r    [ENTRIES];
    logic [31:0]        targetTable_r [ENTRIES];

    logic [IDX_W-1:0]   lkIdx_s;
    logic [TAG_W-1:0]   lkTag_s;
    logic               lkHit_s;
    logic [IDX_W-1:0]   updIdx_s;
    logic [TAG_W-1:0]   updTag_s;
    logic               updHit_s;
    logic               updAccept_s;

    // Byte-offset bits of both PCs never select anything. The prediction
    // echo is only consumed by the statistics counters.
    logic               unusedBits_s;
    assign unusedBits_s = ^{if_pc[1:0], upd_pc[1:0], upd_pred_taken};

    // Fetch-side lookup: split the PC into index and tag and test for a hit.
    always_comb begin
        lkIdx_s = if_pc[IDX_W+1:2];
        lkTag_s = if_pc[31:IDX_W+2];
        lkHit_s = validTable_r[lkIdx_s] && (tagTable_r[lkIdx_s] == lkTag_s);
    end

    // Prediction outputs.
    // The target is forced to zero unless the prediction is taken.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = 32'h0000_0000;
        if (lkHit_s && ctrTable_r[lkIdx_s][1]) begin
            pred_taken  = 1'b1;
            pred_target = targetTable_r[lkIdx_s];
        end else begin
            pred_taken  = 1'b0;
            pred_target = 32'h0000_0000;
        end
    end

    // Update-side decode.
    // An update is accepted only when no clear is requested in the same
    // cycle.
    always_comb begin
        updIdx_s    = upd_pc[IDX_W+1:2];
        updTag_s    = upd_pc[31:IDX_W+2];
        updHit_s    = validTable_r[updIdx_s] && (tagTable_r[updIdx_s] == updTag_s);
        updAccept_s = upd_valid && !btb_clr;
    end

    // Valid bits and counters.
    // The table is cleared asynchronously on reset. Then, in priority order:
    //   - btb_clr invalidates every entry;
    //   - on a hit, the counter steps toward the resolved outcome;
    //   - on a taken miss, the entry is allocated at WT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validTable_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                ctrTable_r[i] <= CTR_WNT;
            end
        end else if (btb_clr) begin
            validTable_r <= {ENTRIES{1'b0}};
        end else if (upd_valid) begin
            if (updHit_s) begin
                ctrTable_r[updIdx_s] <= ctrNext(ctrTable_r[updIdx_s], upd_taken);
            end else if (upd_taken) begin
                validTable_r[updIdx_s] <= 1'b1;
                ctrTable_r[updIdx_s]   <= CTR_WT;
            end else begin
                validTable_r <= validTable_r;
            end
        end else begin
            validTable_r <= validTable_r;
        end
    end

    // Tag and target payload.
    // Rewritten on every accepted taken update, whether it hits or
    // allocates. On a hit the rewritten tag is identical.
    always_ff @(posedge clk) begin
        if (updAccept_s && upd_taken) begin
            tagTable_r[updIdx_s]    <= updTag_s;
            targetTable_r[updIdx_s] <= upd_target;
        end else begin
            tagTable_r[updIdx_s]    <= tagTable_r[updIdx_s];
            targetTable_r[updIdx_s] <= targetTable_r[updIdx_s];
        end
    end

`ifdef BRPRED_STATS_EN
    logic [31:0] statBranches_r;
    logic [31:0] statMispred_r;

    // Performance counters.
    // They count accepted updates and mispredictions, and wrap naturally.
    // btb_clr does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statBranches_r <= 32'd0;
            statMispred_r  <= 32'd0;
        end else if (updAccept_s) begin
            statBranches_r <= statBranches_r + 32'd1;
            if (upd_taken != upd_pred_taken) begin
                statMispred_r <= statMispred_r + 32'd1;
            end else begin
                statMispred_r <= statMispred_r;
            end
        end else begin
            statBranches_r <= statBranches_r;
            statMispred_r  <= statMispred_r;
        end
    end

    assign stat_branches = statBranches_r;
    assign stat_mispred  = statMispred_r;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Self-checking bench for branch_predictor (IDX_W = 4).
// Flow:
//   - a directed vector table;
//   - hand-written multi-cycle sequences (read-old, clear, stats, reset);
//   - randomized traffic checked against a table-of-entries reference model.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int IDX_W   = 4;
    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        btb_clr;
`ifdef BRPRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int total = 0;
    int bad   = 0;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .btb_clr        (btb_clr)
`ifdef BRPRED_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: one record per table slot.
    // The counter is an integer 0..3 (0 = strongly not taken).
    bit          mValid  [ENTRIES];
    int unsigned mTag    [ENTRIES];
    int unsigned mTarget [ENTRIES];
    int          mCtr    [ENTRIES];
    int unsigned mBranches;
    int unsigned mMispred;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0;
            mCtr[i]   = 1;
        end
        mBranches = 0;
        mMispred  = 0;
    endtask

    task automatic modelPredict(input logic [31:0] pc, output logic taken, output logic [31:0] target);
        int unsigned idx;
        int unsigned tag;
        idx = (pc / 4) % ENTRIES;
        tag = pc / (4 * ENTRIES);
        if (mValid[idx] && mTag[idx] == tag && mCtr[idx] >= 2) begin
            taken  = 1'b1;
            target = mTarget[idx];
        end else begin
            taken  = 1'b0;
            target = 32'h0;
        end
    endtask

    task automatic modelUpdate(input logic clr, input logic uv, input logic [31:0] pc,
                               input logic tk, input logic [31:0] tgt, input logic pt);
        int unsigned idx;
        int unsigned tag;
        idx = (pc / 4) % ENTRIES;
        tag = pc / (4 * ENTRIES);
        if (clr) begin
            for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
        end else if (uv) begin
            mBranches++;
            if (tk != pt) mMispred++;
            if (mValid[idx] && mTag[idx] == tag) begin
                mCtr[idx] = tk ? ((mCtr[idx] < 3) ? mCtr[idx] + 1 : 3)
                               : ((mCtr[idx] > 0) ? mCtr[idx] - 1 : 0);
                if (tk) mTarget[idx] = tgt;
            end else if (tk) begin
                mValid[idx]  = 1'b1;
                mTag[idx]    = tag;
                mTarget[idx] = tgt;
                mCtr[idx]    = 2;
            end
        end
    endtask

    task automatic idleInputs();
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_pred_taken = 1'b0;
        btb_clr        = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        idleInputs();
        if_pc = 32'h40;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Update drive, sample one edge later.
    task automatic pulseUpdate(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pt);
        @(negedge clk);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_taken = pt;
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 6)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        return pc;
    endfunction

    typedef struct {
        logic        updValid;
        logic [31:0] updPc;
        logic        updTaken;
        logic [31:0] updTarget;
        logic        clr;
        logic [31:0] ifPc;
        logic        expTaken;
        logic [31:0] expTarget;
    } vec_t;

    vec_t vecs [16];

    // Safety net against a hung run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        eTaken;
        logic [31:0] eTarget;

        // Directed vectors.
        // Index 0 holds 0x40 (tag 1); 0x440 has the same index but tag 0x11.
        vecs[0]  = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h000}; // reset state
        vecs[1]  = '{1'b1, 32'h040, 1'b1, 32'h080, 1'b0, 32'h040, 1'b1, 32'h080}; // alloc WT
        vecs[2]  = '{1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h000}; // WNT
        vecs[3]  = '{1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h000}; // SNT
        vecs[4]  = '{1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b0, 32'h000}; // SNT saturates
        vecs[5]  = '{1'b1, 32'h040, 1'b1, 32'h084, 1'b0, 32'h040, 1'b0, 32'h000}; // WNT
        vecs[6]  = '{1'b1, 32'h040, 1'b1, 32'h088, 1'b0, 32'h040, 1'b1, 32'h088}; // WT, new target
        vecs[7]  = '{1'b1, 32'h040, 1'b1, 32'h088, 1'b0, 32'h040, 1'b1, 32'h088}; // ST
        vecs[8]  = '{1'b1, 32'h040, 1'b1, 32'h088, 1'b0, 32'h040, 1'b1, 32'h088}; // ST saturates
        vecs[9]  = '{1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h040, 1'b1, 32'h088}; // back to WT
        vecs[10] = '{1'b1, 32'h440, 1'b1, 32'h100, 1'b0, 32'h040, 1'b0, 32'h000}; // evicted
        vecs[11] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h440, 1'b1, 32'h100}; // new owner
        vecs[12] = '{1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h440, 1'b1, 32'h100}; // NT miss ignored
        vecs[13] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h443, 1'b1, 32'h100}; // pc[1:0] ignored
        vecs[14] = '{1'b1, 32'h080, 1'b1, 32'h200, 1'b1, 32'h440, 1'b0, 32'h000}; // clear wins
        vecs[15] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h080, 1'b0, 32'h000}; // dropped update

        rst_n = 1'b0;
        if_pc = 32'h40;
        idleInputs();
        #2;
        chk("reset_async_taken", {31'd0, pred_taken}, 32'd0);
        doReset();

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            upd_valid      = vecs[i].updValid;
            upd_pc         = vecs[i].updPc;
            upd_taken      = vecs[i].updTaken;
            upd_target     = vecs[i].updTarget;
            upd_pred_taken = 1'b0;
            btb_clr        = vecs[i].clr;
            @(posedge clk);
            #1;
            idleInputs();
            if_pc = vecs[i].ifPc;
            #1;
            chk($sformatf("vec%0d_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].expTaken});
            chk($sformatf("vec%0d_target", i), pred_target, vecs[i].expTarget);
        end

        // Read-old: during the update cycle the lookup still shows the old
        // entry.
        @(negedge clk);
        if_pc      = 32'h440;
        upd_valid  = 1'b1;
        upd_pc     = 32'h440;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        #1;
        chk("readold_pre_taken", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        idleInputs();
        #1;
        chk("readold_post_taken", {31'd0, pred_taken}, 32'd1);
        chk("readold_post_target", pred_target, 32'h300);

`ifdef BRPRED_STATS_EN
        // Stats: three updates with one misprediction, then a dropped update.
        doReset();
        pulseUpdate(32'h40, 1'b1, 32'h80, 1'b1);
        pulseUpdate(32'h44, 1'b0, 32'h00, 1'b0);
        pulseUpdate(32'h48, 1'b1, 32'hC0, 1'b0);
        chk("stats_branches3", stat_branches, 32'd3);
        chk("stats_mispred1", stat_mispred, 32'd1);
        @(negedge clk);
        btb_clr        = 1'b1;
        upd_valid      = 1'b1;
        upd_pc         = 32'h40;
        upd_taken      = 1'b0;
        upd_pred_taken = 1'b1;
        @(posedge clk);
        #1;
        idleInputs();
        if_pc = 32'h48;
        #1;
        chk("clr_stats_branches", stat_branches, 32'd3);
        chk("clr_stats_mispred", stat_mispred, 32'd1);
        chk("clr_miss_taken", {31'd0, pred_taken}, 32'd0);
`endif

        // Randomized traffic against the model.
        doReset();
        modelReset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if_pc          = randPc();
            upd_valid      = ($urandom_range(0, 99) < 60);
            upd_pc         = randPc();
            upd_taken      = $urandom_range(0, 1);
            upd_target     = $urandom;
            upd_pred_taken = $urandom_range(0, 1);
            btb_clr        = ($urandom_range(0, 99) < 3);
            #1;
            modelPredict(if_pc, eTaken, eTarget);
            chk("rand_taken", {31'd0, pred_taken}, {31'd0, eTaken});
            chk("rand_target", pred_target, eTarget);
            @(posedge clk);
            modelUpdate(btb_clr, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken);
        end
        @(negedge clk);
        idleInputs();
`ifdef BRPRED_STATS_EN
        #1;
        chk("rand_stat_branches", stat_branches, mBranches);
        chk("rand_stat_mispred", stat_mispred, mMispred);
`endif

        // Reset asserted mid-cycle while an update is pending.
        pulseUpdate(32'h40, 1'b1, 32'h80, 1'b0);
        if_pc = 32'h40;
        #1;
        chk("pre_reset_taken", {31'd0, pred_taken}, 32'd1);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h80;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_taken", {31'd0, pred_taken}, 32'd0);
        chk("midreset_target", pred_target, 32'd0);
`ifdef BRPRED_STATS_EN
        chk("midreset_branches", stat_branches, 32'd0);
        chk("midreset_mispred", stat_mispred, 32'd0);
`endif
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;
        #1;
        chk("post_reset_taken", {31'd0, pred_taken}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter IDX_W, default 4, SHALL set the index width, giving 2^IDX_W table entries.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_pc  in  32  fetch-stage PC to predict.
REQ-006 pred_taken  out  1  predicted taken for if_pc.
REQ-007 pred_target  out  32  predicted target; equals the stored target when pred_taken=1, else 0.
REQ-008 upd_valid  in  1  resolved BEQ from ID (Branch=1), update strobe.
REQ-009 upd_pc  in  32  PC of the resolved branch.
REQ-010 upd_taken  in  1  actual branch outcome.
REQ-011 upd_target  in  32  actual branch target.
REQ-012 upd_pred_taken  in  1  prediction that was made for this branch, piped from IF.
REQ-013 btb_clr  in  1  synchronous invalidate-all.

Function
REQ-014 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[31:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-015 Each entry SHALL hold valid, tag, 32-bit target and a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-016 Lookup SHALL be combinational (0-cycle latency): hit = valid && tag match; pred_taken = hit && ctr[1].
REQ-017 Writes SHALL occur only on the rising clk edge; the table SHALL NOT bypass same-cycle updates to lookup (read-old).
REQ-018 On an update hit, the counter SHALL increment saturating at ST when taken and decrement saturating at SNT when not taken.
REQ-019 On an update hit with upd_taken=1, the target SHALL be overwritten with upd_target.
REQ-020 On an update miss with upd_taken=1, the entry SHALL be allocated and SHALL overwrite any valid occupant: valid=1, tag, target, ctr=WT.
REQ-021 On an update miss with upd_taken=0, the table SHALL be left unchanged.
REQ-022 btb_clr SHALL clear all valid bits at the next edge and SHALL take priority over a simultaneous upd_valid, which is dropped.
REQ-023 upd_valid=0 SHALL leave all state unchanged.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, clear all valid bits and set all counters to WNT, and SHALL drive pred_taken=0 and pred_target=0, including mid-update.
REQ-025 Tag and target contents are don't-care after reset; they SHALL never be observable while valid=0.

Configuration
REQ-026 With BRPRED_STATS_EN defined, outputs stat_branches[31:0] and stat_mispred[31:0] SHALL exist.
REQ-027 stat_branches SHALL increment on every accepted upd_valid; btb_clr drops the update and SHALL leave stat_branches unchanged.
REQ-028 stat_mispred SHALL increment on every accepted upd_valid where upd_taken != upd_pred_taken.
REQ-029 Both counters SHALL reset to 0, wrap modulo 2^32, and be unaffected by btb_clr.
REQ-030 Without BRPRED_STATS_EN, the ports and registers SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-031 Reset, then if_pc=0x40 -> pred_taken=0, pred_target=0.
REQ-032 Update pc=0x40, taken, target=0x80; next cycle if_pc=0x40 -> pred_taken=1 (WT), pred_target=0x80.
REQ-033 Two not-taken updates on 0x40 after REQ-032 -> WT->WNT->SNT, pred_taken=0 after the first; a third not-taken update stays at SNT.
REQ-034 Update pc=0x440 (same index, different tag), taken, target=0x100 -> 0x40 misses and 0x440 predicts 0x100.
REQ-035 btb_clr=1 with upd_valid=1 in the same cycle -> all entries miss, update dropped, stat_branches unchanged (stats build).
REQ-036 Stats build, 3 updates with one mismatch -> stat_branches=3, stat_mispred=1; assert rst_n mid-cycle -> both counters and pred_taken read 0 immediately.
